// File: rtl/serial_subtractor_16bit.sv
// Bit-serial 16-bit subtractor: Diff = A - B - Bin, one bit per cycle, LSB first.
// Optional Z/N/V flag logic is built only when SUB_FLAGS_EN is defined.
module serial_subtractor_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Bin,
    output logic [15:0] Diff,
    output logic        Bout,
    output logic        busy,
    output logic        done,
    output logic        Z,
    output logic        N,
    output logic        V
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on acceptance
    // RUN   | 16 full-subtractor bit-steps, LSB first
    // DONE  | one-cycle completion pulse, results valid
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] a_sr, b_sr, res, res_nxt;
    logic        br, br_nxt, d;
    logic [3:0]  cnt;
    logic        last;
    logic        accept;

    assign accept  = (state == IDLE) && start;
    assign last    = (cnt == 4'd15);
    assign d       = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_nxt = {d, res[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            Diff <= '0;
            Bout <= 1'b0;
        end else if (accept) begin
            a_sr <= A;
            b_sr <= B;
            br   <= Bin;
            res  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= {1'b0, a_sr[15:1]};
            b_sr <= {1'b0, b_sr[15:1]};
            br   <= br_nxt;
            res  <= res_nxt;
            cnt  <= cnt + 4'd1;
            if (last) begin
                Diff <= res_nxt;
                Bout <= br_nxt;
            end
        end
    end

`ifdef SUB_FLAGS_EN
    // Operand sign bits are shifted out during RUN, so keep them for V.
    logic a_msb, b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Z     <= 1'b0;
            N     <= 1'b0;
            V     <= 1'b0;
        end else if (accept) begin
            a_msb <= A[15];
            b_msb <= B[15];
        end else if ((state == RUN) && last) begin
            Z <= (res_nxt == 16'h0000);
            N <= res_nxt[15];
            V <= (a_msb != b_msb) && (res_nxt[15] != a_msb);
        end
    end
`else
    assign Z = 1'b0;
    assign N = 1'b0;
    assign V = 1'b0;
`endif

endmodule

// File: doc/serial_subtractor_16bit.md
SERIAL_SUBTRACTOR_16BIT -- requirements
Module: serial_subtractor_16bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  16  minuend; captured on an accepted start.
REQ-006 B  input  16  subtrahend; captured on an accepted start.
REQ-007 Bin  input  1  borrow-in; captured on an accepted start.
REQ-008 Diff  output  16  registered result A - B - Bin, modulo 2^16.
REQ-009 Bout  output  1  registered borrow-out; 1 when A < B + Bin (unsigned).
REQ-010 busy  output  1  high while the operation is in progress (RUN).
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 Z  output  1  zero flag: Diff == 0.
REQ-013 N  output  1  negative flag: Diff[15].
REQ-014 V  output  1  signed overflow flag: (A[15] != B[15]) and (Diff[15] != A[15]).

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start = 1.
- RUN -> DONE after 16 bit-steps.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 An accepted start at edge N SHALL capture A, B and Bin into internal shift registers, load borrow = Bin, and clear the bit counter.
REQ-017 At each edge N+1 through N+16, RUN SHALL process one bit, LSB first, as a full subtractor:
- d = a ^ b ^ br
- br_next = (~a & b) | (~(a ^ b) & br)
REQ-018 Each d bit SHALL shift into a working result register from the MSB side, so that after 16 steps bit i holds result bit i.
REQ-019 At edge N+16 the block SHALL:
- copy the working result to Diff;
- set Bout to the final borrow;
- update Z, N and V;
- enter DONE.
REQ-020 done SHALL be high for exactly the single cycle following edge N+16; fixed latency is 16 cycles from start acceptance to the done pulse.
REQ-021 busy SHALL be high in RUN only, and low in IDLE and DONE.
REQ-022 Diff, Bout, Z, N and V SHALL hold their last completed values until the next completion; they SHALL NOT change during RUN.
REQ-023 start SHALL be ignored in RUN and DONE, with no effect on captured operands or the counter.
REQ-024 A, B and Bin SHALL be don't-care except at the start-acceptance edge; input changes during RUN SHALL NOT affect the result.
REQ-025 Back-to-back operation: a start held high continuously SHALL be accepted in each IDLE cycle, giving one operation per 18 cycles.

Reset
REQ-026 When rst_n = 0, the block SHALL immediately, regardless of clk:
- enter IDLE;
- set Diff = 0x0000, Bout = 0, busy = 0, done = 0, Z = 0, N = 0, V = 0;
- clear the counter and the internal registers.
REQ-027 A reset mid-operation SHALL abandon the operation; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first rising edge with start = 1 SHALL be accepted normally.

Configuration
REQ-029 Macro SUB_FLAGS_EN:
- Defined: Z, N and V SHALL be computed and registered as in REQ-012 to REQ-014 and REQ-019.
- Undefined: Z, N and V SHALL be tied to constant 0 and no flag logic SHALL be synthesised.
- Ports SHALL be present in both cases.

Verification
REQ-030 A=0x1234, B=0x0034, Bin=0 -> done 16 cycles after acceptance; Diff=0x1200, Bout=0, Z=0, N=0, V=0.
REQ-031 A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1, N=1, V=0; A=0x0005, B=0x0003, Bin=1 -> Diff=0x0001, Bout=0.
REQ-032 A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Bout=0, V=1 (flags 0 when SUB_FLAGS_EN is undefined); A=B=0xABCD -> Diff=0x0000, Z=1.
REQ-033 Pulse start with A=0x0010, B=0x0001; pulse start again 5 cycles later with A=0xFFFF -> second start ignored; Diff=0x000F; exactly one done pulse.
REQ-034 Assert rst_n=0 at bit-step 8 of an operation -> all outputs 0 immediately and no done; a subsequent start with A=0x0003, B=0x0002 -> Diff=0x0001.
